// File: rtl/maf_pkg.sv
// Shared MAF datapath constants: row geometry, sideband field layout and the
// occupancy encoding used by the carry-save pipe stage.
package maf_pkg;

    localparam int MAF_W    = 48;
    localparam int MAF_ROWS = 6;

    localparam int CONT_W     = 3;
    localparam int S_W        = 6;
    localparam int TRAP_W     = 8;
    localparam int TRAP_ANS_W = 6;
    localparam int D_W        = 12;
    localparam int E_W        = 12;
    localparam int SH_REV_W   = 74;
    localparam int STI_W      = 4;

    localparam int CONT_LSB     = 0;
    localparam int S_LSB        = CONT_LSB + CONT_W;
    localparam int TRAP_LSB     = S_LSB + S_W;
    localparam int TRAP_ANS_LSB = TRAP_LSB + TRAP_W;
    localparam int D_LSB        = TRAP_ANS_LSB + TRAP_ANS_W;
    localparam int E_LSB        = D_LSB + D_W;
    localparam int SH_REV_LSB   = E_LSB + E_W;
    localparam int STI_LSB      = SH_REV_LSB + SH_REV_W;
    localparam int MAF_SIDE_W   = STI_LSB + STI_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [MAF_SIDE_W-1:0] pack_side(
        input logic [CONT_W-1:0]     cont,
        input logic [S_W-1:0]        s_flags,
        input logic [TRAP_W-1:0]     trap,
        input logic [TRAP_ANS_W-1:0] trap_ans,
        input logic [D_W-1:0]        d,
        input logic [E_W-1:0]        e,
        input logic [SH_REV_W-1:0]   sh_rev,
        input logic [STI_W-1:0]      sti
    );
        logic [MAF_SIDE_W-1:0] side;
        side = '0;
        side[CONT_LSB     +: CONT_W]     = cont;
        side[S_LSB        +: S_W]        = s_flags;
        side[TRAP_LSB     +: TRAP_W]     = trap;
        side[TRAP_ANS_LSB +: TRAP_ANS_W] = trap_ans;
        side[D_LSB        +: D_W]        = d;
        side[E_LSB        +: E_W]        = e;
        side[SH_REV_LSB   +: SH_REV_W]   = sh_rev;
        side[STI_LSB      +: STI_W]      = sti;
        return side;
    endfunction

endpackage

// File: rtl/maf_csa_tree.sv
// Combinational 3:2 carry-save reduction of ROWS rows down to a sum/carry
// pair; each level compresses every full group of three and recurses.
module maf_csa_tree #(
    parameter int WIDTH = 48,
    parameter int ROWS  = 6
) (
    input  logic [ROWS*WIDTH-1:0] rows,
    output logic [WIDTH-1:0]      sum,
    output logic [WIDTH-1:0]      carry
);

    localparam int GROUPS = ROWS / 3;
    localparam int REM    = ROWS % 3;
    localparam int NEXT   = 2 * GROUPS + REM;

    generate
        if (ROWS <= 2) begin : g_leaf
            assign sum = rows[0 +: WIDTH];
            if (ROWS == 2) begin : g_two
                assign carry = rows[WIDTH +: WIDTH];
            end else begin : g_one
                assign carry = '0;
            end
        end else begin : g_level
            logic [NEXT*WIDTH-1:0] next_rows;

            for (genvar g = 0; g < GROUPS; g++) begin : g_csa
                logic [WIDTH-1:0] a, b, c;
                assign a = rows[(3*g)*WIDTH   +: WIDTH];
                assign b = rows[(3*g+1)*WIDTH +: WIDTH];
                assign c = rows[(3*g+2)*WIDTH +: WIDTH];
                assign next_rows[(2*g)*WIDTH +: WIDTH] = a ^ b ^ c;
                // Majority bits move up one weight; the carry out of the MSB is dropped (mod 2^WIDTH).
                assign next_rows[(2*g+1)*WIDTH +: WIDTH] =
                    {(a[WIDTH-2:0] & b[WIDTH-2:0]) |
                     (a[WIDTH-2:0] & c[WIDTH-2:0]) |
                     (b[WIDTH-2:0] & c[WIDTH-2:0]), 1'b0};
            end

            if (REM > 0) begin : g_pass
                assign next_rows[2*GROUPS*WIDTH +: REM*WIDTH] = rows[3*GROUPS*WIDTH +: REM*WIDTH];
            end

            maf_csa_tree #(
                .WIDTH (WIDTH),
                .ROWS  (NEXT)
            ) u_next (
                .rows  (next_rows),
                .sum   (sum),
                .carry (carry)
            );
        end
    endgenerate

endmodule

// File: rtl/maf_csa_pipe_stage.sv
// Carry-save reduction stage with a 2-entry skid buffer (head H, skid K),
// valid/ready handshake and synchronous flush for the MAF pipeline.
module maf_csa_pipe_stage
    import maf_pkg::*;
#(
    parameter int WIDTH  = MAF_W,
    parameter int ROWS   = MAF_ROWS,
    parameter int SIDE_W = MAF_SIDE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*WIDTH-1:0] rows_in,
    input  logic [SIDE_W-1:0]     side_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      sum_out,
    output logic [WIDTH-1:0]      carry_out,
    output logic [SIDE_W-1:0]     side_out,
    output logic [1:0]            occ
);

    logic [WIDTH-1:0] red_sum, red_carry;

    maf_csa_tree #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS)
    ) u_tree (
        .rows  (rows_in),
        .sum   (red_sum),
        .carry (red_carry)
    );

    occ_e              occ_q, occ_d;
    logic              in_ready_q, in_ready_d;
    logic [WIDTH-1:0]  h_sum_q, h_sum_d, h_carry_q, h_carry_d;
    logic [WIDTH-1:0]  k_sum_q, k_sum_d, k_carry_q, k_carry_d;
    logic [SIDE_W-1:0] h_side_q, h_side_d, k_side_q, k_side_d;
    logic              accept, deliver;

    assign out_valid = (occ_q != OCC_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
        occ_d     = occ_q;
        h_sum_d   = h_sum_q;
        h_carry_d = h_carry_q;
        h_side_d  = h_side_q;
        k_sum_d   = k_sum_q;
        k_carry_d = k_carry_q;
        k_side_d  = k_side_q;

        if (flush) begin
            occ_d = OCC_EMPTY;
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d     = OCC_ONE;
                        h_sum_d   = red_sum;
                        h_carry_d = red_carry;
                        h_side_d  = side_in;
                    end
                end
                OCC_ONE: begin
                    if (accept && deliver) begin
                        h_sum_d   = red_sum;
                        h_carry_d = red_carry;
                        h_side_d  = side_in;
                    end else if (accept) begin
                        occ_d     = OCC_FULL;
                        k_sum_d   = red_sum;
                        k_carry_d = red_carry;
                        k_side_d  = side_in;
                    end else if (deliver) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (deliver) begin
                        occ_d     = OCC_ONE;
                        h_sum_d   = k_sum_q;
                        h_carry_d = k_carry_q;
                        h_side_d  = k_side_q;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end

        // Registered ready looks at the next occupancy, so it never depends on out_ready combinationally.
        in_ready_d = (occ_d != OCC_FULL);
    end

    // NOTE: data registers are reset because the outputs are defined as all-zero while rstn is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b0;
            h_sum_q    <= '0;
            h_carry_q  <= '0;
            h_side_q   <= '0;
            k_sum_q    <= '0;
            k_carry_q  <= '0;
            k_side_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
            h_sum_q    <= h_sum_d;
            h_carry_q  <= h_carry_d;
            h_side_q   <= h_side_d;
            k_sum_q    <= k_sum_d;
            k_carry_q  <= k_carry_d;
            k_side_q   <= k_side_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign sum_out   = h_sum_q;
    assign carry_out = h_carry_q;
    assign side_out  = h_side_q;
    assign occ       = occ_q;

endmodule
